cla_multi_operand_addsub: RTL and testbench
===========================================

// Module: cla_multi_operand_addsub
// PURPOSE
//  Parametrised sequential add/subtract unit: controller FSM plus a datapath with a carry-lookahead core.
//  It accepts NUM_OPS operands over a valid/ready bus and folds each one into an accumulator.
//  It reports the result with sticky carry/borrow and sticky signed-overflow flags, then pulses done.
//  It is the generalised successor of the fixed 16-bit two-operand CLA adder datapath/controller pair.
// PARAMETERS
//  N        16  operand/accumulator width; N must be a multiple of G
//  G        4   CLA group width; group generate/propagate are combined by a second-level lookahead
//  NUM_OPS  2   operands per transaction, >= 2
// PORTS
//  clk       in   1    single clock, rising edge
//  rst_n     in   1    asynchronous active-low reset
//  start     in   1    begin a transaction; sampled in IDLE and DONE only
//  sub       in   1    mode, captured at start: 0 = add, 1 = subtract
//  cin       in   1    carry-in, captured at start; used in add mode only
//  abort     in   1    synchronous cancel of the transaction in progress
//  in_valid  in   1    data_in holds an operand
//  in_ready  out  1    unit accepts an operand this cycle
//  data_in   in   N    operand bus
//  busy      out  1    high in LOAD
//  done      out  1    one-cycle pulse: result registers were updated last edge
//  data_out  out  N+1  {carry_flag, result[N-1:0]}
//  overflow  out  1    sticky two's-complement overflow of the transaction
// BEHAVIOUR
//  Reset (rst_n low, any time, including mid-transaction):
//   - state = IDLE; acc, operand count, data_out, overflow, done, busy and in_ready all 0.
//  States:
//   - IDLE:  in_ready = 0. start -> LOAD; sub and cin are captured; count is cleared.
//   - LOAD:  in_ready = busy = 1. A beat is in_valid & in_ready; count increments per beat.
//       - Beat 0: acc <= data_in; carry and overflow stickies cleared.
//       - Beat k >= 1, add: acc <= acc + data_in + (k==1 ? cin : 0).
//       - Beat k >= 1, sub: acc <= acc + ~data_in + 1.
//       - Per-step carry = CLA carry-out (add) or ~carry-out, i.e. borrow (sub); ORed into the sticky carry.
//       - Per-step signed overflow is computed from operand MSBs and result MSB; ORed into sticky overflow.
//       - The beat with count == NUM_OPS-1 -> DONE. data_out = {carry_sticky, acc_next} and overflow are
//         registered on that same edge.
//   - DONE:  done = 1 for exactly this cycle; in_ready = busy = 0.
//       - start -> LOAD (back-to-back transaction, new sub/cin captured); otherwise -> IDLE.
//  Latency: done is high the cycle after the final operand beat. Throughput: one operand per cycle.
//  Width: acc wraps modulo 2^N; the only width extension is data_out[N], which holds the sticky carry.
//  data_out and overflow hold their value until the final beat of the next completed transaction.
//  Boundary conditions:
//   - start while in LOAD: ignored.
//   - in_valid low: LOAD stalls indefinitely; no timeout.
//   - abort in LOAD: -> IDLE next edge; no done; data_out and overflow unchanged.
//   - abort with start (IDLE/DONE): abort wins; state -> IDLE.
//   - abort on the final beat: beat discarded; no done.
//  The CLA core is purely combinational between acc and the acc register; there are no internal pipeline
//  stages, and the timing path is one N-bit two-level lookahead add.
// TESTING
//  1. N=16, NUM_OPS=2, add, cin=1: AAAA, 1111 -> data_out=17'h0BBBC, overflow=0, done 1 cycle after beat 1.
//  2. Add, cin=0: FFFF, 0001 -> data_out=17'h10000, overflow=0.
//     Add, cin=0: 7FFF, 0001 -> data_out=17'h08000, overflow=1.
//  3. Sub: 0005, 0007 -> data_out=17'h1FFFE (borrow), overflow=0.
//     Sub: 8000, 0001 -> data_out=17'h07FFF, overflow=1.
//  4. NUM_OPS=3, add, cin=0: 4000, 4000, 4000 -> data_out=17'h0C000, overflow=1 (sticky from step 1).
//     Back-to-back start in DONE -> LOAD with no IDLE cycle.
//  5. Stall/abort:
//     - in_valid low for 5 cycles between beats -> same result as scenario 1.
//     - abort after beat 0 -> IDLE, no done, data_out keeps its previous value.
//     - start pulsed in LOAD -> no effect.
//  6. Reset: rst_n low for 1 ns mid-LOAD (between edges) -> all outputs 0 immediately, IDLE.
//     Then a new transaction runs as in scenario 1.

Source files
------------

// File: rtl/cla_multi_operand_addsub.sv
// Sequential multi-operand add/subtract unit: valid/ready operand intake, accumulator folded
// through a two-level carry-lookahead adder, sticky carry/borrow and signed-overflow flags.

module cla_multi_operand_addsub_cla #(
  parameter int N = 16,
  parameter int G = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         c_i,
  output logic [N-1:0] sum_o,
  output logic         c_o
);
  localparam int NG = N / G;

  logic [N-1:0]  bit_g, bit_p, bit_c;
  logic [NG-1:0] grp_g, grp_p;
  logic [NG:0]   grp_c;

  assign bit_g = a_i & b_i;
  assign bit_p = a_i ^ b_i;

  genvar gi;
  generate
    for (gi = 0; gi < NG; gi++) begin : g_grp
      logic [G-1:0] gg_l, pp_l, bc_l;
      logic         grp_g_l;

      assign gg_l = bit_g[gi*G +: G];
      assign pp_l = bit_p[gi*G +: G];

      // Group generate as a flat sum of products so it is a single lookahead level.
      always_comb begin
        logic t;
        grp_g_l = 1'b0;
        for (int k = 0; k < G; k++) begin
          t = gg_l[k];
          for (int m = k + 1; m < G; m++) t = t & pp_l[m];
          grp_g_l = grp_g_l | t;
        end
      end

      // Bit carries inside the group, looked ahead from the group carry-in.
      always_comb begin
        logic t;
        logic s;
        bc_l = '0;
        for (int k = 0; k < G; k++) begin
          t = grp_c[gi];
          for (int m = 0; m < k; m++) t = t & pp_l[m];
          s = t;
          for (int j = 0; j < k; j++) begin
            t = gg_l[j];
            for (int m = j + 1; m < k; m++) t = t & pp_l[m];
            s = s | t;
          end
          bc_l[k] = s;
        end
      end

      assign grp_g[gi]           = grp_g_l;
      assign grp_p[gi]           = &pp_l;
      assign bit_c[gi*G +: G]    = bc_l;
    end
  endgenerate

  // Second-level lookahead over the group generate/propagate pairs.
  always_comb begin
    logic t;
    logic s;
    grp_c    = '0;
    grp_c[0] = c_i;
    for (int j = 1; j <= NG; j++) begin
      t = c_i;
      for (int m = 0; m < j; m++) t = t & grp_p[m];
      s = t;
      for (int i = 0; i < j; i++) begin
        t = grp_g[i];
        for (int m = i + 1; m < j; m++) t = t & grp_p[m];
        s = s | t;
      end
      grp_c[j] = s;
    end
  end

  assign sum_o = bit_p ^ bit_c;
  assign c_o   = grp_c[NG];
endmodule

module cla_multi_operand_addsub #(
  parameter int N       = 16,
  parameter int G       = 4,
  parameter int NUM_OPS = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         sub,
  input  logic         cin,
  input  logic         abort,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] data_in,
  output logic         busy,
  output logic         done,
  output logic [N:0]   data_out,
  output logic         overflow
);
  localparam int CW = $clog2(NUM_OPS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sub_q, sub_d;
  logic          cin_q, cin_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic [N:0]    dout_q, dout_d;
  logic          oflow_q, oflow_d;

  logic [N-1:0]  opnd_b;
  logic          cla_cin;
  logic [N-1:0]  sum;
  logic          cla_cout;
  logic          step_carry;
  logic          step_ovf;
  logic          beat;
  logic          last_beat;

  // Subtraction is acc + ~x + 1; the external carry-in only feeds the first add step.
  assign opnd_b  = sub_q ? ~data_in : data_in;
  assign cla_cin = sub_q | (cin_q & (cnt_q == CW'(1)));

  cla_multi_operand_addsub_cla #(.N(N), .G(G)) u_cla (
    .a_i   (acc_q),
    .b_i   (opnd_b),
    .c_i   (cla_cin),
    .sum_o (sum),
    .c_o   (cla_cout)
  );

  assign step_carry = sub_q ? ~cla_cout : cla_cout;
  assign step_ovf   = (acc_q[N-1] == opnd_b[N-1]) && (sum[N-1] != acc_q[N-1]);
  assign beat       = in_valid && (state_q == S_LOAD);
  assign last_beat  = (cnt_q == CW'(NUM_OPS - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sub_d   = sub_q;
    cin_d   = cin_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    dout_d  = dout_q;
    oflow_d = oflow_q;

    case (state_q)
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (beat) begin
          cnt_d = CW'(cnt_q + 1'b1);
          if (cnt_q == '0) begin
            acc_d   = data_in;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
          end else begin
            acc_d   = sum;
            carry_d = carry_q | step_carry;
            ovf_d   = ovf_q | step_ovf;
            if (last_beat) begin
              dout_d  = {carry_q | step_carry, sum};
              oflow_d = ovf_q | step_ovf;
              state_d = S_DONE;
            end
          end
        end
      end
      default: begin
        // IDLE and DONE behave alike: abort dominates, start opens a new transaction.
        state_d = S_IDLE;
        if (!abort && start) begin
          state_d = S_LOAD;
          sub_d   = sub;
          cin_d   = cin;
          cnt_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sub_q   <= 1'b0;
      cin_q   <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      dout_q  <= '0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sub_q   <= sub_d;
      cin_q   <= cin_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      dout_q  <= dout_d;
      oflow_q <= oflow_d;
    end
  end

  assign in_ready = (state_q == S_LOAD);
  assign busy     = (state_q == S_LOAD);
  assign done     = (state_q == S_DONE);
  assign data_out = dout_q;
  assign overflow = oflow_q;
endmodule

// File: tb/tb_cla_multi_operand_addsub.sv
// Directed bench: a two-operand unit for the main, stall, abort and reset cases,
// and a three-operand unit for sticky overflow and back-to-back transactions.

module tb_cla_multi_operand_addsub;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        a_start = 0, a_sub = 0, a_cin = 0, a_abort = 0, a_in_valid = 0;
  logic [15:0] a_data_in = '0;
  logic        a_in_ready, a_busy, a_done, a_overflow;
  logic [16:0] a_data_out;

  logic        b_start = 0, b_sub = 0, b_cin = 0, b_abort = 0, b_in_valid = 0;
  logic [15:0] b_data_in = '0;
  logic        b_in_ready, b_busy, b_done, b_overflow;
  logic [16:0] b_data_out;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cla_multi_operand_addsub #(.N(16), .G(4), .NUM_OPS(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(a_start), .sub(a_sub), .cin(a_cin), .abort(a_abort),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .data_in(a_data_in), .busy(a_busy),
    .done(a_done), .data_out(a_data_out), .overflow(a_overflow)
  );

  cla_multi_operand_addsub #(.N(16), .G(4), .NUM_OPS(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(b_start), .sub(b_sub), .cin(b_cin), .abort(b_abort),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .data_in(b_data_in), .busy(b_busy),
    .done(b_done), .data_out(b_data_out), .overflow(b_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Two-operand transaction on unit A with an optional stall between the beats.
  task automatic a_txn(input string tag, input logic s, input logic ci,
                       input logic [15:0] x, input logic [15:0] y,
                       input logic [16:0] exp_d, input logic exp_o, input int stall);
    a_start = 1; a_sub = s; a_cin = ci;
    tick;
    a_start = 0; a_sub = ~s; a_cin = ~ci;
    chk({tag, ".busy"}, 32'(a_busy), 32'd1);
    a_in_valid = 1; a_data_in = x;
    tick;
    a_in_valid = 0; a_data_in = 16'h0;
    for (int i = 0; i < stall; i++) begin
      chk({tag, ".stall_done"}, 32'(a_done), 32'd0);
      tick;
    end
    a_in_valid = 1; a_data_in = y;
    tick;
    a_in_valid = 0; a_data_in = 16'h0;
    chk({tag, ".done"}, 32'(a_done), 32'd1);
    chk({tag, ".data_out"}, 32'(a_data_out), 32'(exp_d));
    chk({tag, ".overflow"}, 32'(a_overflow), 32'(exp_o));
    chk({tag, ".in_ready"}, 32'(a_in_ready), 32'd0);
    tick;
    chk({tag, ".done_pulse"}, 32'(a_done), 32'd0);
  endtask

  initial begin
    #3;
    chk("rst.busy", 32'(a_busy), 32'd0);
    chk("rst.in_ready", 32'(a_in_ready), 32'd0);
    chk("rst.done", 32'(a_done), 32'd0);
    chk("rst.data_out", 32'(a_data_out), 32'd0);
    chk("rst.overflow", 32'(a_overflow), 32'd0);
    #9 rst_n = 1'b1;
    tick;

    a_txn("s1_add_cin",  1'b0, 1'b1, 16'hAAAA, 16'h1111, 17'h0BBBC, 1'b0, 0);
    a_txn("s2_carry",    1'b0, 1'b0, 16'hFFFF, 16'h0001, 17'h10000, 1'b0, 0);
    a_txn("s2_ovf",      1'b0, 1'b0, 16'h7FFF, 16'h0001, 17'h08000, 1'b1, 0);
    a_txn("s3_borrow",   1'b1, 1'b0, 16'h0005, 16'h0007, 17'h1FFFE, 1'b0, 0);
    a_txn("s3_sub_ovf",  1'b1, 1'b0, 16'h8000, 16'h0001, 17'h07FFF, 1'b1, 0);
    a_txn("s5_stall",    1'b0, 1'b1, 16'hAAAA, 16'h1111, 17'h0BBBC, 1'b0, 5);

    // Abort after beat 0: back to IDLE, no done, result registers untouched.
    a_start = 1; a_sub = 1;
    tick;
    a_start = 0; a_sub = 0; a_in_valid = 1; a_data_in = 16'h1234;
    tick;
    a_in_valid = 0; a_abort = 1;
    tick;
    a_abort = 0;
    chk("abort.busy", 32'(a_busy), 32'd0);
    chk("abort.done", 32'(a_done), 32'd0);
    chk("abort.data_out", 32'(a_data_out), 32'h0BBBC);
    tick;
    chk("abort.idle_done", 32'(a_done), 32'd0);

    // start pulsed in LOAD with different mode bits must not restart or recapture.
    a_start = 1; a_sub = 0; a_cin = 0;
    tick;
    a_start = 0; a_in_valid = 1; a_data_in = 16'h0001;
    tick;
    a_in_valid = 0; a_start = 1; a_sub = 1; a_cin = 1;
    tick;
    a_start = 0; a_sub = 0; a_cin = 0;
    chk("startload.busy", 32'(a_busy), 32'd1);
    a_in_valid = 1; a_data_in = 16'h0002;
    tick;
    a_in_valid = 0;
    chk("startload.done", 32'(a_done), 32'd1);
    chk("startload.data_out", 32'(a_data_out), 32'h00003);
    tick;

    // Abort coinciding with the final beat discards it.
    a_start = 1;
    tick;
    a_start = 0; a_in_valid = 1; a_data_in = 16'h1111;
    tick;
    a_data_in = 16'h2222; a_abort = 1;
    tick;
    a_in_valid = 0; a_abort = 0;
    chk("abortlast.done", 32'(a_done), 32'd0);
    chk("abortlast.busy", 32'(a_busy), 32'd0);
    chk("abortlast.data_out", 32'(a_data_out), 32'h00003);

    // Abort together with start in IDLE keeps the unit idle.
    a_start = 1; a_abort = 1;
    tick;
    a_start = 0; a_abort = 0;
    chk("abortstart.busy", 32'(a_busy), 32'd0);

    // Unit B: three operands, sticky overflow, then back-to-back subtract.
    b_start = 1;
    tick;
    b_start = 0; b_in_valid = 1; b_data_in = 16'h4000;
    repeat (3) tick;
    b_in_valid = 0; b_start = 1; b_sub = 1;
    chk("s4.done", 32'(b_done), 32'd1);
    chk("s4.data_out", 32'(b_data_out), 32'h0C000);
    chk("s4.overflow", 32'(b_overflow), 32'd1);
    tick;
    b_start = 0; b_sub = 0;
    chk("s4b2b.busy", 32'(b_busy), 32'd1);
    chk("s4b2b.done", 32'(b_done), 32'd0);
    b_in_valid = 1; b_data_in = 16'h0010;
    tick;
    b_data_in = 16'h0003;
    chk("s4b2b.hold", 32'(b_data_out), 32'h0C000);
    tick;
    b_data_in = 16'h0004;
    tick;
    b_in_valid = 0;
    chk("s4b2b.done2", 32'(b_done), 32'd1);
    chk("s4b2b.data_out", 32'(b_data_out), 32'h00009);
    chk("s4b2b.overflow", 32'(b_overflow), 32'd0);
    tick;

    // Reset pulse between edges in the middle of a transaction.
    a_start = 1;
    tick;
    a_start = 0; a_in_valid = 1; a_data_in = 16'h5555;
    tick;
    a_in_valid = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("midrst.busy", 32'(a_busy), 32'd0);
    chk("midrst.in_ready", 32'(a_in_ready), 32'd0);
    chk("midrst.data_out", 32'(a_data_out), 32'd0);
    chk("midrst.b_data_out", 32'(b_data_out), 32'd0);
    chk("midrst.b_overflow", 32'(b_overflow), 32'd0);
    #1 rst_n = 1'b1;
    tick;
    chk("midrst.idle", 32'(a_busy), 32'd0);
    a_txn("s6_after_rst", 1'b0, 1'b1, 16'hAAAA, 16'h1111, 17'h0BBBC, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
